vending_ctrl_param: RTL and testbench
=====================================

# vending_ctrl_param

Parametrised vending-machine controller and the next generation of the fixed-price 5/10 coin FSM. Accumulates coin credit against a configurable price, dispenses when credit reaches the price and returns change serially as 5-unit pulses. Adds cancel/refund, coin rejection while busy, a visible credit count and an optional 25-unit coin. Sits between the coin-acceptor decode logic and the dispenser/change-hopper drivers.

## Interface
- PRICE_U, default 4: item price in 5-unit steps (4 = 20). Must be ≥ 1.
- CREDIT_W, default 4: width of the credit and change counters. Must satisfy 2^CREDIT_W > PRICE_U + 4.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- coin  input  2  coin strobe, valid for one cycle per coin: 00 = idle, 01 = 5, 10 = 10, 11 = 25 (only with VEND_COIN25_EN).
- cancel  input  1  refund request, sampled each cycle.
- dispense  output  1  one-cycle pulse per vended item.
- chg5  output  1  high for one cycle per 5 units returned.
- coin_rej  output  1  one-cycle pulse when a coin is rejected.
- busy  output  1  high when the state is not COLLECT.
- credit  output  CREDIT_W  accumulated credit in 5-unit steps.

## Operation
- There are three states: COLLECT, VEND and CHANGE. All outputs are registered. busy is decoded from the state register.
- Coin values in 5-unit steps: 01 = 1, 10 = 2, 11 = 5.
- **COLLECT, valid coin.** Compute sum = credit + value. Arithmetic is CREDIT_W bits wide and cannot overflow under the parameter rule.
  - If sum ≥ PRICE_U: go to VEND, load change = sum − PRICE_U, clear credit.
  - Otherwise: credit ← sum.
- **COLLECT, cancel with credit + value > 0.** Go to CHANGE with change = credit + value and clear credit. No dispense. A coin in the same cycle is accepted and then refunded.
- **Cancel versus coin priority.** If a coin completes the price in the same cycle as cancel, cancel wins and nothing is vended.
- **Cancel with zero credit and no coin.** Ignored.
- **VEND.** Lasts one cycle, then goes to CHANGE.
- **CHANGE.** On each edge with change > 0: assert chg5 for the next cycle and decrement change. On the edge where change = 0: return to COLLECT.
- **Coins while busy.** Any coin ≠ 00 arriving in VEND or CHANGE is not credited, and coin_rej pulses in the following cycle. cancel is ignored while busy.
- **Invalid code 11.** When VEND_COIN25_EN is not defined, code 11 in COLLECT is rejected the same way (coin_rej pulse, no credit).

## Timing
- **Reset.** Takes effect at the next edge and overrides every other input at that edge. Resulting values: state = COLLECT, credit = 0, change = 0, and dispense, chg5, coin_rej and busy all 0. Reset mid-vend or mid-change drops the outstanding change with no further pulses.
- **Completing coin at edge E0:**
  - dispense is high for E0→E1 and busy goes high at E0.
  - The state is VEND for E0→E1, then CHANGE from E1.
  - With N units of change, chg5 is high for N consecutive cycles, E2→E(N+2).
  - The state returns to COLLECT at edge E(N+2). busy falls there, and a new coin is accepted from that cycle onward.
- **Cancel at edge E0 with refund N.** The state is CHANGE from E0, chg5 is high E1→E(N+1), and COLLECT is re-entered at E(N+1).
- **coin_rej latency.** Registered pulse one cycle after the rejected strobe.
- **credit latency.** credit reflects an accepted coin one cycle after its strobe.

## Configuration
- **VEND_COIN25_EN defined:** coin 11 is worth 5 units and is handled like any other valid coin, including the vend and refund paths.
- **VEND_COIN25_EN not defined:** coin 11 is always rejected (coin_rej pulse) and never changes credit or state.
- The parameter rule (2^CREDIT_W > PRICE_U + 4) is unchanged in both builds.

## Test plan
All scenarios use PRICE_U = 4, CREDIT_W = 4 and VEND_COIN25_EN defined unless noted.
- **Reset:** hold rst 2 cycles with random coin/cancel → all outputs 0, credit = 0.
- **Exact price:** coins 10, 10 → credit 2 after the first coin; one dispense pulse after the second; 0 chg5 cycles; busy high 2 cycles.
- **Overpay:** coins 10, 5, 10 (sum 5) → one dispense pulse and chg5 high exactly 1 cycle. A single 25 from zero gives the same response. Without VEND_COIN25_EN the single 25 instead gives a coin_rej pulse with credit staying 0.
- **Cancel:** coins 5, 10, then cancel → no dispense, chg5 high 3 cycles, credit returns to 0.
- **Cancel + completing coin:** credit 3 plus coin 10 with cancel in the same cycle → no dispense, chg5 high 5 cycles.
- **Coin while busy, and reset mid-change:**
  - Coin 10 during CHANGE → coin_rej pulse next cycle, credit unchanged at 0, refund count unchanged.
  - Assert rst mid-CHANGE → chg5 low from the next edge and the state returns to COLLECT.

Source files
------------

// File: rtl/vending_ctrl_param.sv
// Parametrised vending controller: accumulates coin credit, vends at PRICE_U, refunds serially as 5-unit pulses.
// Define VEND_COIN25_EN to accept coin code 11 as a 25-unit coin; otherwise code 11 is always rejected.
module vending_ctrl_param #(
    parameter int PRICE_U  = 4,
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                dispense,
    output logic                chg5,
    output logic                coin_rej,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_VEND    = 2'd1,
        S_CHANGE  = 2'd2
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_U);

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            2'b01:   return CREDIT_W'(1);
            2'b10:   return CREDIT_W'(2);
`ifdef VEND_COIN25_EN
            2'b11:   return CREDIT_W'(5);
`else
            2'b11:   return '0;
`endif
            default: return '0;
        endcase
    endfunction

    function automatic logic coin_accepted(input logic [1:0] code);
`ifdef VEND_COIN25_EN
        return code != 2'b00;
`else
        return (code == 2'b01) || (code == 2'b10);
`endif
    endfunction

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [CREDIT_W-1:0]   change_q, change_d;
    logic                  dispense_q, dispense_d;
    logic                  chg5_q, chg5_d;
    logic                  coin_rej_q, coin_rej_d;
    logic [CREDIT_W-1:0]   sum;
    logic                  accept;

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        change_d   = change_q;
        dispense_d = 1'b0;
        chg5_d     = 1'b0;
        coin_rej_d = 1'b0;
        // A rejected code contributes zero, so sum collapses to the held credit.
        sum        = credit_q + coin_value(coin);
        accept     = coin_accepted(coin);

        case (state_q)
            S_COLLECT: begin
                coin_rej_d = (coin != 2'b00) && !accept;
                if (cancel && (sum != '0)) begin
                    state_d  = S_CHANGE;
                    change_d = sum;
                    credit_d = '0;
                end else if (accept) begin
                    if (sum >= PRICE_C) begin
                        state_d    = S_VEND;
                        change_d   = sum - PRICE_C;
                        credit_d   = '0;
                        dispense_d = 1'b1;
                    end else begin
                        credit_d = sum;
                    end
                end
            end
            S_VEND: begin
                coin_rej_d = coin != 2'b00;
                state_d    = S_CHANGE;
            end
            S_CHANGE: begin
                coin_rej_d = coin != 2'b00;
                if (change_q != '0) begin
                    chg5_d   = 1'b1;
                    change_d = change_q - CREDIT_W'(1);
                end else begin
                    state_d = S_COLLECT;
                end
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_COLLECT;
            credit_q   <= '0;
            change_q   <= '0;
            dispense_q <= 1'b0;
            chg5_q     <= 1'b0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            change_q   <= change_d;
            dispense_q <= dispense_d;
            chg5_q     <= chg5_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    assign dispense = dispense_q;
    assign chg5     = chg5_q;
    assign coin_rej = coin_rej_q;
    assign busy     = state_q != S_COLLECT;
    assign credit   = credit_q;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Bench for vending_ctrl_param: directed scenarios plus random traffic against a timeline model.
module tb_vending_ctrl_param;

    localparam int PRICE_U  = 4;
    localparam int CREDIT_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          coin;
    logic                cancel;
    logic                dispense;
    logic                chg5;
    logic                coin_rej;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    vending_ctrl_param #(.PRICE_U(PRICE_U), .CREDIT_W(CREDIT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .coin     (coin),
        .cancel   (cancel),
        .dispense (dispense),
        .chg5     (chg5),
        .coin_rej (coin_rej),
        .busy     (busy),
        .credit   (credit)
    );

    always #5 clk = ~clk;

    int cyc, n_cmp, n_fail;
    // Model: each transaction is a schedule of edge indices at which outputs are expected.
    int m_credit, busy_end, disp_edge, chg_first, chg_last, rej_edge;
    int cnt_disp, cnt_chg, cnt_busy, cnt_rej;

    function automatic int coin_units(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
`ifdef VEND_COIN25_EN
            2'b11:   return 5;
`else
            2'b11:   return 0;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic model_edge(input logic [1:0] c, input logic cn, input logic r);
        int k, val, sum, n;
        k = cyc + 1;
        if (r) begin
            m_credit  = 0;
            busy_end  = k;
            disp_edge = -1;
            chg_first = 1;
            chg_last  = 0;
            rej_edge  = -1;
            return;
        end
        if (k - 1 >= busy_end) begin
            val = coin_units(c);
            sum = m_credit + val;
            if (c != 2'b00 && val == 0) rej_edge = k;
            if (cn && sum > 0) begin
                n         = sum;
                busy_end  = k + n + 1;
                chg_first = k + 1;
                chg_last  = k + n;
                m_credit  = 0;
            end else if (val > 0) begin
                if (sum >= PRICE_U) begin
                    n         = sum - PRICE_U;
                    disp_edge = k;
                    busy_end  = k + n + 2;
                    chg_first = k + 2;
                    chg_last  = k + n + 1;
                    m_credit  = 0;
                end else begin
                    m_credit = sum;
                end
            end
        end else if (c != 2'b00) begin
            rej_edge = k;
        end
    endtask

    function automatic logic [7:0] model_vec();
        logic [7:0] v;
        v[7]   = (cyc == disp_edge);
        v[6]   = (cyc >= chg_first) && (cyc <= chg_last);
        v[5]   = (cyc == rej_edge);
        v[4]   = (cyc < busy_end);
        v[3:0] = 4'(m_credit);
        return v;
    endfunction

    task automatic step(input logic [1:0] c, input logic cn, input logic r);
        coin   = c;
        cancel = cn;
        rst    = r;
        model_edge(c, cn, r);
        @(posedge clk);
        #1;
        cyc++;
        cnt_disp += int'(dispense);
        cnt_chg  += int'(chg5);
        cnt_busy += int'(busy);
        cnt_rej  += int'(coin_rej);
    endtask

    task automatic drain(input int n);
        repeat (n) step(2'b00, 1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        cnt_disp = 0;
        cnt_chg  = 0;
        cnt_busy = 0;
        cnt_rej  = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
            n_cmp++;
            if ({dispense, chg5, coin_rej, busy, credit} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h want 00", cyc,
                         {dispense, chg5, coin_rej, busy, credit});
            end
        end
        step(2'b00, 1'b0, 1'b0);
        n_cmp++;
        if ({dispense, chg5, coin_rej, busy, credit} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release: got %h want 00", {dispense, chg5, coin_rej, busy, credit});
        end
    endtask

    task automatic test_exact_price();
        clear_counts();
        step(2'b10, 1'b0, 1'b0);
        n_cmp++;
        if (credit !== 4'd2) begin
            n_fail++;
            $display("FAIL exact_credit: got %0d want 2", credit);
        end
        step(2'b10, 1'b0, 1'b0);
        n_cmp++;
        if ({dispense, busy, credit} !== 6'b11_0000) begin
            n_fail++;
            $display("FAIL exact_vend_edge: disp %b busy %b credit %0d want 1 1 0", dispense, busy, credit);
        end
        drain(10);
        n_cmp++;
        if (cnt_disp !== 1 || cnt_chg !== 0 || cnt_busy !== 2) begin
            n_fail++;
            $display("FAIL exact_counts: disp %0d chg %0d busy %0d want 1 0 2", cnt_disp, cnt_chg, cnt_busy);
        end
    endtask

    task automatic test_overpay();
        clear_counts();
        step(2'b10, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        n_cmp++;
        if (credit !== 4'd3) begin
            n_fail++;
            $display("FAIL overpay_credit: got %0d want 3", credit);
        end
        step(2'b10, 1'b0, 1'b0);
        drain(10);
        n_cmp++;
        if (cnt_disp !== 1 || cnt_chg !== 1 || cnt_busy !== 3) begin
            n_fail++;
            $display("FAIL overpay_counts: disp %0d chg %0d busy %0d want 1 1 3", cnt_disp, cnt_chg, cnt_busy);
        end
        clear_counts();
        step(2'b11, 1'b0, 1'b0);
        drain(10);
`ifdef VEND_COIN25_EN
        n_cmp++;
        if (cnt_disp !== 1 || cnt_chg !== 1 || cnt_rej !== 0) begin
            n_fail++;
            $display("FAIL coin25_vend: disp %0d chg %0d rej %0d want 1 1 0", cnt_disp, cnt_chg, cnt_rej);
        end
`else
        n_cmp++;
        if (cnt_disp !== 0 || cnt_chg !== 0 || cnt_rej !== 1 || cnt_busy !== 0 || credit !== 4'd0) begin
            n_fail++;
            $display("FAIL coin25_reject: disp %0d chg %0d rej %0d busy %0d credit %0d want 0 0 1 0 0",
                     cnt_disp, cnt_chg, cnt_rej, cnt_busy, credit);
        end
`endif
    endtask

    task automatic test_cancel();
        clear_counts();
        step(2'b01, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        n_cmp++;
        if ({busy, credit} !== 5'b1_0000) begin
            n_fail++;
            $display("FAIL cancel_edge: busy %b credit %0d want 1 0", busy, credit);
        end
        drain(10);
        n_cmp++;
        if (cnt_disp !== 0 || cnt_chg !== 3 || credit !== 4'd0) begin
            n_fail++;
            $display("FAIL cancel_counts: disp %0d chg %0d credit %0d want 0 3 0", cnt_disp, cnt_chg, credit);
        end
    endtask

    task automatic test_cancel_with_coin();
        clear_counts();
        step(2'b01, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b10, 1'b1, 1'b0);
        drain(10);
        n_cmp++;
        if (cnt_disp !== 0 || cnt_chg !== 5 || cnt_busy !== 6) begin
            n_fail++;
            $display("FAIL cancel_coin_counts: disp %0d chg %0d busy %0d want 0 5 6", cnt_disp, cnt_chg, cnt_busy);
        end
    endtask

    task automatic test_busy_coin_and_reset();
        clear_counts();
        step(2'b01, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        n_cmp++;
        if ({coin_rej, credit} !== 5'b1_0000) begin
            n_fail++;
            $display("FAIL busy_coin_rej: rej %b credit %0d want 1 0", coin_rej, credit);
        end
        drain(8);
        n_cmp++;
        if (cnt_chg !== 3 || cnt_rej !== 1 || credit !== 4'd0) begin
            n_fail++;
            $display("FAIL busy_coin_counts: chg %0d rej %0d credit %0d want 3 1 0", cnt_chg, cnt_rej, credit);
        end
        clear_counts();
        step(2'b01, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        n_cmp++;
        if (chg5 !== 1'b1) begin
            n_fail++;
            $display("FAIL midchange_pulse: got %b want 1", chg5);
        end
        step(2'b00, 1'b0, 1'b1);
        n_cmp++;
        if ({chg5, busy, credit} !== 6'b00_0000) begin
            n_fail++;
            $display("FAIL midchange_reset: chg5 %b busy %b credit %0d want 0 0 0", chg5, busy, credit);
        end
        drain(5);
        n_cmp++;
        if (cnt_chg !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_chg: chg %0d busy %b want 1 0", cnt_chg, busy);
        end
    endtask

    task automatic test_random();
        logic [1:0] c;
        logic       cn, r;
        int         sel;
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                6:       c = 2'b01;
                7:       c = 2'b10;
                8:       c = 2'b11;
                9:       c = 2'($urandom_range(1, 3));
                default: c = 2'b00;
            endcase
            cn = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 99) == 0);
            step(c, cn, r);
            n_cmp++;
            if ({dispense, chg5, coin_rej, busy, credit} !== model_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got disp/chg/rej/busy/credit %h want %h", cyc,
                         {dispense, chg5, coin_rej, busy, credit}, model_vec());
            end
        end
    endtask

    initial begin
        cyc       = 0;
        n_cmp     = 0;
        n_fail    = 0;
        m_credit  = 0;
        busy_end  = 0;
        disp_edge = -1;
        chg_first = 1;
        chg_last  = 0;
        rej_edge  = -1;
        rst       = 1'b1;
        coin      = 2'b00;
        cancel    = 1'b0;
        clear_counts();
        test_reset();
        test_exact_price();
        test_overpay();
        test_cancel();
        test_cancel_with_coin();
        test_busy_coin_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
